lemming_dig_arbiter: RTL

- Shares a single "shovel" (the dig permission) among N lemming FSM instances.
- Lemmings request via level-sensitive dig_req.
- The arbiter issues a one-cycle dig pulse to exactly one lemming, confirms the lemming entered its digging state, holds ownership until digging ends (it fell through), then enforces a cooldown before re-arbitrating round-robin.
- Sits between level/player logic and the dig inputs of the lemming array.

---
 rtl/lemmings_pkg.sv | 26 ++
 rtl/lemming_dig_arbiter_rr_pick.sv | 31 +++
 rtl/lemming_dig_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming array: FSM state encodings and the
// default timing constants of the dig-permission arbiter.
package lemmings_pkg;

    localparam int DEF_CONFIRM_CYC = 2;
    localparam int DEF_COOL_CYC    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CONFIRM,
        HOLD,
        COOLDOWN
    } dig_arb_state_t;

    typedef enum logic [2:0] {
        WALK_LEFT,
        WALK_RIGHT,
        FALL_LEFT,
        FALL_RIGHT,
        DIG_LEFT,
        DIG_RIGHT,
        SPLATTER
    } lemming_state_t;

endpackage

// File: rtl/lemming_dig_arbiter_rr_pick.sv
// Round-robin picker: rotates the request vector so the slot after 'last'
// sits at bit 0, then takes the lowest set bit of the rotated view.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;

    always_comb begin
        rot = '0;
        for (int p = 0; p < N; p++) begin
            rot[p] = req[(int'(last) + 1 + p) % N];
        end
        // Descending scan so the lowest rotated position wins.
        idx = '0;
        for (int p = N - 1; p >= 0; p--) begin
            if (rot[p]) begin
                idx = IW'((int'(last) + 1 + p) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/lemming_dig_arbiter.sv
// Hands the single dig permission to one lemming at a time: one-cycle pulse,
// confirm the dig started, hold until it ends, cool down, then re-arbitrate.
module lemming_dig_arbiter
    import lemmings_pkg::*;
#(
    parameter int N           = 4,
    parameter int CONFIRM_CYC = DEF_CONFIRM_CYC,
    parameter int COOL_CYC    = DEF_COOL_CYC,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [N-1:0]         dig_req,
    input  logic [N-1:0]         digging,
    input  logic [N-1:0]         aaah,
    output logic [N-1:0]         dig_pulse,
    output logic [$clog2(N)-1:0] owner,
    output logic                 owner_valid,
    output logic [CNT_W-1:0]     grants_total
);

    localparam int IW   = $clog2(N);
    localparam int CMAX = (CONFIRM_CYC > COOL_CYC) ? CONFIRM_CYC : COOL_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYC - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYC - 1);

    dig_arb_state_t state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] grants_q, grants_d;
    logic [N-1:0]     pulse_q, pulse_d;
    logic             valid_q, valid_d;

    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .req  (dig_req),
        .last (owner_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        grants_d = grants_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CONFIRM;
                cnt_d   = '0;
            end
            CONFIRM: begin
                if (digging[owner_q]) begin
                    state_d = HOLD;
                    if (grants_q != '1) grants_d = grants_q + CNT_W'(1);
                end else if (aaah[owner_q] || cnt_q == CONF_LAST) begin
                    state_d = COOLDOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!digging[owner_q]) begin
                    state_d = COOLDOWN;
                    cnt_d   = '0;
                end
            end
            COOLDOWN: begin
                if (cnt_q == COOL_LAST) state_d = IDLE;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        pulse_d = (state_d == ISSUE) ? ({{(N-1){1'b0}}, 1'b1} << owner_d) : '0;
        valid_d = (state_d == ISSUE) || (state_d == CONFIRM) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q  <= IDLE;
            owner_q  <= IW'(N - 1);
            cnt_q    <= '0;
            grants_q <= '0;
            pulse_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            grants_q <= grants_d;
            pulse_q  <= pulse_d;
            valid_q  <= valid_d;
        end
    end

    assign dig_pulse    = pulse_q;
    assign owner        = owner_q;
    assign owner_valid  = valid_q;
    assign grants_total = grants_q;

endmodule
